// File: rtl/imm_pack.sv
// imm_pack: encodes a 32-bit constant as one or two (imm[15:0], eop[1:0]) words.
// When the immediate extender expands these words, it reproduces the original value.
// A split constant is rebuilt as ext(word1) | ext(word2).
//
// Ports:
//   clk, reset              clock and asynchronous active-high reset
//   in_valid/in_ready       input stream handshake; in_value is the constant
//   out_valid/out_ready     output stream handshake
//   out_imm, out_eop        immediate field and extender op
//                           (00 sext, 01 zext, 10 lui, 11 sext<<2)
//   out_last                marks the final word of a constant
//   split_cnt               saturating count of split constants
//                           (present only with IMM_PACK_CNT_EN)
//
// Parameter SHIFT_MODE: 1 allows the single-word sext<<2 encoding (eop=11).
// Optional feature macro: IMM_PACK_CNT_EN (adds the split_cnt port and counter).
//
// state | meaning
// IDLE  | waiting for a constant, in_ready high
// EMIT1 | presenting first (or only) word
// EMIT2 | presenting low half of a split constant, last=1
module imm_pack #(
  parameter bit SHIFT_MODE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_imm,
  output logic [1:0]  out_eop,
  output logic        out_last
`ifdef IMM_PACK_CNT_EN
  ,
  output logic [15:0] split_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, EMIT1, EMIT2} state_t;

  state_t      state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] out_imm_q, out_imm_d;
  logic [1:0]  out_eop_q, out_eop_d;
  logic        out_last_q, out_last_d;
  logic [15:0] lo_q, lo_d;

  logic [15:0] cls_imm;
  logic [1:0]  cls_eop;
  logic        cls_split;
  logic        accept;

  assign in_ready  = (state_q == IDLE) && !reset;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_imm   = out_imm_q;
  assign out_eop   = out_eop_q;
  assign out_last  = out_last_q;

  // Classification, first match wins.
  always_comb begin
    cls_imm   = in_value[31:16];
    cls_eop   = 2'b10;
    cls_split = 1'b1;
    if ((&in_value[31:15]) || !(|in_value[31:15])) begin
      cls_imm   = in_value[15:0];
      cls_eop   = 2'b00;
      cls_split = 1'b0;
    end else if (!(|in_value[31:16])) begin
      cls_imm   = in_value[15:0];
      cls_eop   = 2'b01;
      cls_split = 1'b0;
    end else if (!(|in_value[15:0])) begin
      cls_imm   = in_value[31:16];
      cls_eop   = 2'b10;
      cls_split = 1'b0;
    end else if (SHIFT_MODE && (in_value[1:0] == 2'b00) &&
                 ((&in_value[31:17]) || !(|in_value[31:17]))) begin
      cls_imm   = in_value[17:2];
      cls_eop   = 2'b11;
      cls_split = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_imm_d   = out_imm_q;
    out_eop_d   = out_eop_q;
    out_last_d  = out_last_q;
    lo_d        = lo_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = EMIT1;
          out_valid_d = 1'b1;
          out_imm_d   = cls_imm;
          out_eop_d   = cls_eop;
          out_last_d  = !cls_split;
          lo_d        = in_value[15:0];
        end
      end
      EMIT1: begin
        if (out_valid_q && out_ready) begin
          if (out_last_q) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_imm_d   = 16'h0000;
            out_eop_d   = 2'b00;
            out_last_d  = 1'b0;
          end else begin
            // Low half always goes out zero-extended so the OR rebuild is exact.
            state_d    = EMIT2;
            out_imm_d  = lo_q;
            out_eop_d  = 2'b01;
            out_last_d = 1'b1;
          end
        end
      end
      EMIT2: begin
        if (out_valid_q && out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          out_imm_d   = 16'h0000;
          out_eop_d   = 2'b00;
          out_last_d  = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        out_imm_d   = 16'h0000;
        out_eop_d   = 2'b00;
        out_last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_imm_q   <= 16'h0000;
      out_eop_q   <= 2'b00;
      out_last_q  <= 1'b0;
      lo_q        <= 16'h0000;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_imm_q   <= out_imm_d;
      out_eop_q   <= out_eop_d;
      out_last_q  <= out_last_d;
      lo_q        <= lo_d;
    end
  end

`ifdef IMM_PACK_CNT_EN
  logic [15:0] split_cnt_q, split_cnt_d;

  always_comb begin
    split_cnt_d = split_cnt_q;
    if (accept && cls_split && (split_cnt_q != 16'hFFFF)) begin
      split_cnt_d = split_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      split_cnt_q <= 16'h0000;
    end else begin
      split_cnt_q <= split_cnt_d;
    end
  end

  assign split_cnt = split_cnt_q;
`endif

endmodule
